fib_sequencer: RTL and testbench

Wishbone-controlled sequencer for the fibonacci generator. Clears the generator, advances it a programmed number of terms (or free-runs), captures the final term, counts terms, flags wrap-around overflow and raises an interrupt. Sits between the caravel Wishbone bus and the fibonacci datapath inside wrapper. The generator's value is still routed to io_out.

---
 rtl/fib_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_fib_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fib_sequencer.sv
// fib_sequencer: Wishbone-controlled sequencer for an external fibonacci generator.
// It clears the generator, then advances it TARGET terms or free-runs. At the end of a
// run it captures the final term in RESULT, sets a sticky done flag and can raise an
// interrupt. It also flags wrap-around of the generator value.
//
// Ports:
//   clk, reset        single clock; synchronous active-high reset
//   wb_*              Wishbone slave (stb/cyc/we/sel/adr/dat in, ack/dat out)
//   fib_clear         one-cycle clear pulse to the generator
//   fib_en            advance the generator one term per cycle while high
//   fib_value         current generator term
//   busy              sequencer is not idle
//   irq               level interrupt, irq_en & done
//
// Register map (word offset = wb_adr_i[4:2]):
//   0 CTRL   b0 start (pulse), b1 abort (pulse), b2 irq_en, b3 free_run
//   1 TARGET term count, byte-lane writable
//   2 STATUS b0 busy, b1 done (W1C), b2 overflow (W1C)
//   3 RESULT final term (RO)
//   4 COUNT  terms advanced (RO)
module fib_sequencer #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned CNT_W     = 16,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wb_stb_i,
  input  logic             wb_cyc_i,
  input  logic             wb_we_i,
  input  logic [3:0]       wb_sel_i,
  input  logic [31:0]      wb_adr_i,
  input  logic [31:0]      wb_dat_i,
  output logic             wb_ack_o,
  output logic [31:0]      wb_dat_o,
  output logic             fib_clear,
  output logic             fib_en,
  input  logic [WIDTH-1:0] fib_value,
  output logic             busy,
  output logic             irq
);

  typedef enum logic [1:0] {StIdle, StClear, StRun} state_e;

  state_e             r_state, w_state_d;
  logic               r_ack;
  logic [31:0]        r_dat;
  logic               r_irq_en, r_free_run, r_done, r_overflow;
  logic [CNT_W-1:0]   r_target, r_count;
  logic [WIDTH-1:0]   r_result, r_prev;

  logic               w_req, w_hit, w_wr;
  logic [2:0]         w_off;
  logic               w_wr_ctrl, w_wr_tgt, w_wr_stat;
  logic               w_start, w_abort, w_start_ok, w_finish;
  logic [31:0]        w_be_mask, w_rdata;
  logic               w_unused;

  // A request is only seen while ack is low, so back-to-back strobes ack every other cycle.
  assign w_req     = wb_stb_i & wb_cyc_i & ~r_ack;
  assign w_hit     = (wb_adr_i[31:5] == BASE_ADDR[31:5]);
  assign w_off     = wb_adr_i[4:2];
  assign w_wr      = w_req & wb_we_i & w_hit;
  assign w_wr_ctrl = w_wr & (w_off == 3'd0) & wb_sel_i[0];
  assign w_wr_tgt  = w_wr & (w_off == 3'd1);
  assign w_wr_stat = w_wr & (w_off == 3'd2) & wb_sel_i[0];
  // Abort takes priority over a start carried by the same write.
  assign w_abort   = w_wr_ctrl & wb_dat_i[1];
  assign w_start   = w_wr_ctrl & wb_dat_i[0] & ~wb_dat_i[1];

  assign w_be_mask = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
  assign w_unused  = ^{wb_adr_i[1:0], w_be_mask[31:CNT_W], wb_dat_i[31:CNT_W]};

  assign busy     = (r_state != StIdle);
  assign irq      = r_irq_en & r_done;
  assign wb_ack_o = r_ack;
  assign wb_dat_o = r_dat;

  always_ff @(posedge clk) begin
    if (reset) r_state <= StIdle;
    else       r_state <= w_state_d;
  end

  always_comb begin
    w_state_d  = r_state;
    fib_clear  = 1'b0;
    fib_en     = 1'b0;
    w_finish   = 1'b0;
    w_start_ok = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_start) begin
          w_start_ok = 1'b1;
          w_state_d  = StClear;
        end
      end
      StClear: begin
        fib_clear = 1'b1;
        w_state_d = StRun;
      end
      StRun: begin
        // Live comparison: TARGET and free_run written mid-run apply on the next cycle.
        if (r_free_run || (r_count < r_target)) begin
          fib_en = 1'b1;
        end else begin
          w_finish  = 1'b1;
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
    if (w_abort) begin
      w_state_d = StIdle;
      fib_en    = 1'b0;
      w_finish  = 1'b0;
    end
    // Keep the generator frozen in the very cycle reset is sampled.
    if (reset) begin
      fib_en    = 1'b0;
      fib_clear = 1'b0;
    end
  end

  always_comb begin
    w_rdata = '0;
    if (w_hit) begin
      case (w_off)
        3'd0:    w_rdata[3:0]       = {r_free_run, r_irq_en, 2'b00};
        3'd1:    w_rdata[CNT_W-1:0] = r_target;
        3'd2:    w_rdata[2:0]       = {r_overflow, r_done, busy};
        3'd3:    w_rdata[WIDTH-1:0] = r_result;
        3'd4:    w_rdata[CNT_W-1:0] = r_count;
        default: w_rdata            = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ack      <= 1'b0;
      r_dat      <= '0;
      r_irq_en   <= 1'b0;
      r_free_run <= 1'b0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
      r_target   <= '0;
      r_count    <= '0;
      r_result   <= '0;
      r_prev     <= '0;
    end else begin
      r_ack <= w_req;
      r_dat <= w_req ? w_rdata : 32'd0;

      if (w_wr_ctrl) begin
        r_irq_en   <= wb_dat_i[2];
        r_free_run <= wb_dat_i[3];
      end
      if (w_wr_tgt) begin
        r_target <= (r_target & ~w_be_mask[CNT_W-1:0]) |
                    (wb_dat_i[CNT_W-1:0] & w_be_mask[CNT_W-1:0]);
      end
      if (w_wr_stat && wb_dat_i[1]) r_done     <= 1'b0;
      if (w_wr_stat && wb_dat_i[2]) r_overflow <= 1'b0;

      if (w_start_ok) begin
        r_done     <= 1'b0;
        r_overflow <= 1'b0;
        r_count    <= '0;
      end
      if (r_state == StClear) begin
        r_count <= '0;
        r_prev  <= '0;
      end
      if (fib_en) begin
        r_prev <= fib_value;
        if (r_count != {CNT_W{1'b1}}) r_count <= r_count + 1'b1;
      end
      // A term smaller than its predecessor means the generator wrapped.
      if ((r_state == StRun) && (r_count >= CNT_W'(2)) && (fib_value < r_prev)) begin
        r_overflow <= 1'b1;
      end
      // Hardware sets come last so they win over a same-edge W1C.
      if (w_finish) begin
        r_result <= fib_value;
        r_done   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fib_sequencer.sv
// Self-checking bench for fib_sequencer. It includes a behavioural fibonacci generator
// and a reference model (fib_mod / fib_wraps) that computes expected terms and
// overflow with plain arithmetic.
module tb_fib_sequencer;

  localparam logic [31:0] ACtrl   = 32'h3000_0000;
  localparam logic [31:0] ATarget = 32'h3000_0004;
  localparam logic [31:0] AStatus = 32'h3000_0008;
  localparam logic [31:0] AResult = 32'h3000_000C;
  localparam logic [31:0] ACount  = 32'h3000_0010;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wb_stb_i = 1'b0, wb_cyc_i = 1'b0, wb_we_i = 1'b0;
  logic [3:0]  wb_sel_i = 4'h0;
  logic [31:0] wb_adr_i = '0, wb_dat_i = '0;
  logic        wb_ack_o;
  logic [31:0] wb_dat_o;
  logic        fib_clear, fib_en, busy, irq;
  logic [31:0] fib_value;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] last_result = '0;

  fib_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .wb_stb_i  (wb_stb_i),
    .wb_cyc_i  (wb_cyc_i),
    .wb_we_i   (wb_we_i),
    .wb_sel_i  (wb_sel_i),
    .wb_adr_i  (wb_adr_i),
    .wb_dat_i  (wb_dat_i),
    .wb_ack_o  (wb_ack_o),
    .wb_dat_o  (wb_dat_o),
    .fib_clear (fib_clear),
    .fib_en    (fib_en),
    .fib_value (fib_value),
    .busy      (busy),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  // Behavioural generator sitting outside the sequencer.
  logic [31:0] g_a = 32'd0, g_b = 32'd1;
  always @(posedge clk) begin
    if (fib_clear) begin
      g_a <= 32'd0;
      g_b <= 32'd1;
    end else if (fib_en) begin
      g_a <= g_b;
      g_b <= g_a + g_b;
    end
  end
  assign fib_value = g_a;

  function automatic logic [31:0] fib_mod(input int n);
    logic [31:0] a = 32'd0, b = 32'd1, t;
    for (int i = 0; i < n; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  function automatic logic fib_wraps(input int n);
    for (int k = 2; k <= n; k++) begin
      if (fib_mod(k) < fib_mod(k - 1)) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel);
    @(negedge clk);
    wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel;
    wb_we_i = 1'b1; wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
    @(negedge clk);
    check_eq("wr_ack", 64'(wb_ack_o), 64'd1);
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic wb_read(input logic [31:0] adr, output logic [31:0] d);
    @(negedge clk);
    wb_adr_i = adr; wb_sel_i = 4'hF;
    wb_we_i = 1'b0; wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
    @(negedge clk);
    check_eq("rd_ack", 64'(wb_ack_o), 64'd1);
    d = wb_dat_o;
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [31:0] adr, input logic [31:0] exp);
    logic [31:0] d;
    wb_read(adr, d);
    check_eq(tag, 64'(d), 64'(exp));
  endtask

  // Programs TARGET, starts a run and checks timing, result and flags against the model.
  task automatic run_target(input int n, input logic ie);
    int ens = 0;
    logic [31:0] exp_res = fib_mod(n);
    logic exp_ovf = fib_wraps(n);
    wb_write(ATarget, 32'(n), 4'hF);
    wb_write(ACtrl, (32'(ie) << 2) | 32'd1, 4'hF);
    check_eq("clear_pulse", 64'(fib_clear), 64'd1);
    for (int k = 1; k <= n + 2; k++) begin
      @(negedge clk);
      if (fib_en) ens++;
      if (k == n + 1) begin
        check_eq("busy_before_done", 64'(busy), 64'd1);
        check_eq("irq_before_done", 64'(irq), 64'd0);
      end
    end
    check_eq("en_cycles", 64'(ens), 64'(n));
    check_eq("busy_after_done", 64'(busy), 64'd0);
    check_eq("irq_level", 64'(irq), 64'(ie));
    read_check("result", AResult, exp_res);
    read_check("count", ACount, 32'(n));
    read_check("status", AStatus, {29'd0, exp_ovf, 1'b1, 1'b0});
    last_result = exp_res;
    wb_write(AStatus, 32'd6, 4'hF);
    check_eq("irq_after_w1c", 64'(irq), 64'd0);
    read_check("status_w1c", AStatus, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    // Reset state.
    repeat (2) @(negedge clk);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_irq", 64'(irq), 64'd0);
    check_eq("rst_ack", 64'(wb_ack_o), 64'd0);
    check_eq("rst_dat", 64'(wb_dat_o), 64'd0);
    check_eq("rst_en", 64'(fib_en), 64'd0);
    check_eq("rst_clear", 64'(fib_clear), 64'd0);
    reset = 1'b0;

    // Directed runs from the test plan.
    run_target(10, 1'b1);
    check_eq("fib10_const", 64'(last_result), 64'd55);
    run_target(10, 1'b0);
    run_target(0, 1'b1);
    run_target(47, 1'b0);
    check_eq("fib47_const", 64'(last_result), 64'd2971215073);
    run_target(48, 1'b1);
    check_eq("fib48_const", 64'(last_result), 64'd512559680);

    // Randomised term counts, including ones that wrap.
    for (int i = 0; i < 6; i++) begin
      n = int'($urandom_range(0, 60));
      run_target(n, 1'(($urandom & 32'd1)));
    end

    // Free run: start, ignored restart, abort after 20 enabled edges.
    wb_write(ACtrl, 32'h9, 4'hF);
    repeat (8) @(negedge clk);
    wb_write(ACtrl, 32'h9, 4'hF);
    repeat (10) @(negedge clk);
    wb_write(ACtrl, 32'h2, 4'hF);
    check_eq("abort_busy", 64'(busy), 64'd0);
    check_eq("abort_en", 64'(fib_en), 64'd0);
    read_check("abort_count", ACount, 32'd20);
    read_check("abort_status", AStatus, 32'd0);
    read_check("abort_result", AResult, last_result);

    // TARGET byte lanes.
    wb_write(ATarget, 32'h1234, 4'hF);
    wb_write(ATarget, 32'hABCD, 4'b0010);
    read_check("target_lanes", ATarget, 32'hAB34);

    // Unmapped offset and foreign base.
    read_check("unmapped_off", 32'h3000_0014, 32'd0);
    read_check("foreign_base", 32'h3000_0020, 32'd0);
    wb_write(32'h3000_0020, 32'd1, 4'hF);
    check_eq("foreign_start", 64'(busy), 64'd0);

    // Held strobe: ack every other cycle, dat_o zero while ack low.
    wb_write(ATarget, 32'h5A, 4'hF);
    @(negedge clk);
    wb_adr_i = ATarget; wb_we_i = 1'b0; wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_eq("b2b_ack", 64'(wb_ack_o), 64'((k % 2) == 0));
      check_eq("b2b_dat", 64'(wb_dat_o), (k % 2) == 0 ? 64'h5A : 64'd0);
    end
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("idle_ack", 64'(wb_ack_o), 64'd0);
    check_eq("idle_dat", 64'(wb_dat_o), 64'd0);

    // Reset in the middle of a run, at COUNT=5.
    wb_write(ATarget, 32'd10, 4'hF);
    wb_write(ACtrl, 32'h5, 4'hF);
    repeat (6) @(negedge clk);
    check_eq("en_before_rst", 64'(fib_en), 64'd1);
    reset = 1'b1;
    #1;
    check_eq("en_in_rst", 64'(fib_en), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    check_eq("rst_run_busy", 64'(busy), 64'd0);
    check_eq("rst_run_irq", 64'(irq), 64'd0);
    read_check("rst_ctrl", ACtrl, 32'd0);
    read_check("rst_target", ATarget, 32'd0);
    read_check("rst_status", AStatus, 32'd0);
    read_check("rst_result", AResult, 32'd0);
    read_check("rst_count", ACount, 32'd0);

    // Start with byte lane 0 disabled is ignored.
    wb_write(ATarget, 32'd3, 4'hF);
    wb_write(ACtrl, 32'd1, 4'b0010);
    check_eq("sel_start_clear", 64'(fib_clear), 64'd0);
    check_eq("sel_start_busy", 64'(busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
